delay_timer_n: RTL and testbench
================================

Name: delay_timer_n

Overview:
- Parametrised successor to the fixed 0-to-7 delay counter in the microwave encoder path.
- Counts 0..limit with a run-time limit, in periodic or one-shot mode, and emits a one-cycle `delay` pulse at each terminal count.
- Adds start/abort/pause control plus busy/done status, so the microwave controller can time heating, beep and display-refresh intervals from one block.

Parameters:
- WIDTH, 3, counter and limit width in bits. Must be >= 1. The default with limit=7 reproduces the 0..7 sequence.

Ports:
- clk    in   1      system clock; all logic on rising edge
- clear  in   1      reset, synchronous, active-high
- start  in   1      capture limit/mode and (re)start counting from 0
- limit  in   WIDTH  terminal count; sampled only on an accepted start
- mode   in   1      0 = periodic (auto-wrap), 1 = one-shot; sampled with start
- pause  in   1      hold count while high (RUN only)
- abort  in   1      stop and return to IDLE
- count  out  WIDTH  current count value (registered)
- busy   out  1      high while in RUN
- delay  out  1      one-cycle terminal-count pulse (registered)
- done   out  1      one-shot completion flag (level)

Behaviour:
- Clocking: single clock. Every output is a register; there are no combinational paths from inputs to outputs.
- Reset (clear=1 at an edge): state=IDLE, count=0, busy=0, delay=0, done=0, captured limit=0, captured mode=0. Clear overrides every other input.
- Input priority per edge: clear > abort > start > pause > normal counting.
- States:
  - IDLE: count=0, busy=0.
  - RUN: counting, busy=1.
  - DONE: one-shot finished, done=1, count holds the captured limit.
- Start (any state, abort low):
  - Captures limit into lim_q and mode into mode_q.
  - Sets count=0, state=RUN, busy=1, done=0, delay=0.
  - Restart in RUN is allowed. It suppresses any terminal event in that cycle (no delay pulse).
- RUN, pause=0, count != lim_q: count <= count+1, delay <= 0.
- RUN, pause=0, count == lim_q (terminal edge):
  - delay <= 1 for exactly one cycle.
  - mode_q=0: count <= 0, stay in RUN.
  - mode_q=1: count holds lim_q, state=DONE, busy <= 0, done <= 1.
- RUN, pause=1: count, state and busy hold. delay <= 0. No terminal event while paused.
- Abort (RUN or DONE): state=IDLE, count=0, busy=0, done=0, delay=0. Abort in IDLE has no effect.
- DONE: holds until start, abort or clear. pause is ignored.
- IDLE/DONE: pause is ignored and delay stays 0.
- Timing: with start accepted at edge E0, count=k after edge Ek. The first delay pulse is high after edge E(L+1), where L=lim_q. In periodic mode, period = L+1 cycles, measured as pulse rising edge to pulse rising edge with pause low.
- Limit 0:
  - Periodic: delay high on every cycle from E1 onward; count stays 0.
  - One-shot: DONE and a single pulse after E1.
- Width/arithmetic:
  - count never exceeds lim_q.
  - Wrap is explicit (to 0), never by overflow.
  - lim_q = 2^WIDTH-1 must work with no X/overflow artefacts.
- Changes on limit/mode while running have no effect until the next start.
- Reset mid-operation: the next cycle shows the reset values regardless of state, pause or terminal count.

Test Plan:
- clear; start with limit=7, mode=0; run 20 cycles.
  - count 0..7 then 0..; delay high only after E8 and E16; busy=1 throughout; done=0.
- start with limit=3, mode=1.
  - count 0,1,2,3; single delay after E4; then done=1, busy=0, count stays 3.
  - A later start gives done=0 and count=0 next cycle.
- WIDTH=3, limit=7, periodic; pause high for 3 cycles while count=2.
  - count holds 2; first delay moves from E8 to E11; no delay while paused.
- abort at count=5.
  - Next cycle: IDLE, count=0, busy=0, delay=0.
  - abort+start in the same cycle: abort wins, block stays IDLE.
- limit=0 periodic.
  - delay=1 on every cycle after E1; count=0.
  - Change limit input to 5 mid-run: no effect until the next start.
- start asserted in RUN exactly when count==lim_q.
  - No delay pulse; count=0.
  - clear at count=4: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/delay_timer_n_if.sv
// Control/status bundle for delay_timer_n.
// The master drives the timer controls. The slave is the timer itself,
// which returns the count and status.
interface delay_timer_n_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic [WIDTH-1:0] limit;
    logic             mode;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             delay;
    logic             done;

    modport master (
        output start, limit, mode, pause, abort,
        input  count, busy, delay, done
    );

    modport slave (
        input  start, limit, mode, pause, abort,
        output count, busy, delay, done
    );
endinterface

// File: rtl/delay_timer_n.sv
// Programmable delay counter with periodic and one-shot modes.
// It counts from 0 to a captured limit and pulses `delay` for one cycle at each
// terminal count. Every output is a register, so no path runs from an input
// straight to an output.
module delay_timer_n #(
    parameter int WIDTH = 3
) (
    input  logic           clk,
    input  logic           clear,
    delay_timer_n_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lim_q;
    logic             mode_q;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             delay;
    logic             done;

    // The terminal compare uses the captured limit, never the live input.
    // This keeps limit changes during a run from affecting that run.
    logic at_limit;
    assign at_limit = (count == lim_q);

    // Single state machine. Priority is clear > abort > start > pause > count.
    // Wrapping to 0 is done explicitly, so lim_q = all-ones never relies on
    // counter overflow.
    always_ff @(posedge clk) begin
        if (clear) begin
            state  <= IDLE;
            lim_q  <= '0;
            mode_q <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            delay  <= 1'b0;
            done   <= 1'b0;
        end else if (bus.abort) begin
            // In IDLE these values already hold, so abort there changes nothing.
            // It still blocks a simultaneous start.
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            delay <= 1'b0;
            done  <= 1'b0;
        end else if (bus.start) begin
            // A restart also overrides any terminal event in this cycle.
            state  <= RUN;
            lim_q  <= bus.limit;
            mode_q <= bus.mode;
            count  <= '0;
            busy   <= 1'b1;
            delay  <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.pause) begin
                        delay <= 1'b0;
                    end else if (at_limit) begin
                        delay <= 1'b1;
                        if (mode_q) begin
                            // One-shot: count stays at the limit.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            count <= '0;
                        end
                    end else begin
                        count <= count + WIDTH'(1);
                        delay <= 1'b0;
                    end
                end
                DONE: begin
                    delay <= 1'b0;
                end
                default: begin
                    // IDLE, and also recovery from any unreachable encoding.
                    state <= IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                    delay <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count = count;
    assign bus.busy  = busy;
    assign bus.delay = delay;
    assign bus.done  = done;

endmodule

// File: tb/tb_delay_timer_n.sv
// Directed test of delay_timer_n using hand-computed expectations.
module tb_delay_timer_n;

    logic clk;
    logic clear;
    int   passed;
    int   failed;
    int   total;

    delay_timer_n_if #(.WIDTH(3)) bus ();

    delay_timer_n #(.WIDTH(3)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge. Inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int b, input int dl, input int dn);
        chk({tag, ".count"}, int'(bus.count), c);
        chk({tag, ".busy"},  int'(bus.busy),  b);
        chk({tag, ".delay"}, int'(bus.delay), dl);
        chk({tag, ".done"},  int'(bus.done),  dn);
    endtask

    initial begin
        passed = 0; failed = 0; total = 0;
        clear = 1'b1;
        bus.start = 1'b0; bus.limit = '0; bus.mode = 1'b0;
        bus.pause = 1'b0; bus.abort = 1'b0;
        tick();
        chk_all("reset", 0, 0, 0, 0);
        clear = 1'b0;
        tick();
        chk_all("idle", 0, 0, 0, 0);

        // Periodic, limit 7: count k%8, with a pulse after E8 and E16.
        bus.start = 1'b1; bus.limit = 3'd7; bus.mode = 1'b0;
        tick();
        bus.start = 1'b0;
        chk_all("per7.E0", 0, 1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk_all($sformatf("per7.E%0d", k), k % 8, 1, (k % 8 == 0) ? 1 : 0, 0);
        end

        // One-shot, limit 3.
        bus.start = 1'b1; bus.limit = 3'd3; bus.mode = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_all("os3.E0", 0, 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_all($sformatf("os3.E%0d", k), k, 1, 0, 0);
        end
        tick();
        chk_all("os3.E4", 3, 0, 1, 1);
        bus.pause = 1'b1;
        tick();
        chk_all("os3.E5", 3, 0, 0, 1);
        tick();
        chk_all("os3.E6", 3, 0, 0, 1);
        bus.pause = 1'b0;
        bus.start = 1'b1; bus.mode = 1'b0; bus.limit = 3'd7;
        tick();
        bus.start = 1'b0;
        chk_all("os3.restart", 0, 1, 0, 0);

        // Pause for 3 cycles at count 2 moves the first pulse from E8 to E11.
        bus.start = 1'b1; bus.limit = 3'd7; bus.mode = 1'b0;
        tick();
        bus.start = 1'b0;
        chk_all("pause.E0", 0, 1, 0, 0);
        for (int k = 1; k <= 11; k++) begin
            bus.pause = (k >= 3 && k <= 5);
            // limit input wiggle must be ignored mid-run
            bus.limit = 3'd1;
            tick();
            if (k <= 2)       chk_all($sformatf("pause.E%0d", k), k, 1, 0, 0);
            else if (k <= 5)  chk_all($sformatf("pause.E%0d", k), 2, 1, 0, 0);
            else if (k <= 10) chk_all($sformatf("pause.E%0d", k), k - 3, 1, 0, 0);
            else              chk_all($sformatf("pause.E%0d", k), 0, 1, 1, 0);
        end
        bus.pause = 1'b0;

        // Abort at count 5, then abort together with start.
        bus.start = 1'b1; bus.limit = 3'd7;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        chk("abort.pre", int'(bus.count), 5);
        bus.abort = 1'b1;
        tick();
        chk_all("abort", 0, 0, 0, 0);
        bus.start = 1'b1;
        tick();
        chk_all("abort+start", 0, 0, 0, 0);
        bus.abort = 1'b0; bus.start = 1'b0;
        tick();
        chk_all("abort.idle", 0, 0, 0, 0);

        // Limit 0, periodic: a pulse every cycle from E1 onward.
        bus.start = 1'b1; bus.limit = 3'd0; bus.mode = 1'b0;
        tick();
        bus.start = 1'b0;
        chk_all("lim0.E0", 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) bus.limit = 3'd5;
            tick();
            chk_all($sformatf("lim0.E%0d", k), 0, 1, 1, 0);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_all("lim5.E0", 0, 1, 0, 0);
        tick();
        chk_all("lim5.E1", 1, 1, 0, 0);

        // One-shot, limit 0: a single pulse and DONE after E1.
        bus.start = 1'b1; bus.limit = 3'd0; bus.mode = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk_all("os0.E1", 0, 0, 1, 1);
        tick();
        chk_all("os0.E2", 0, 0, 0, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_all("os0.abort", 0, 0, 0, 0);

        // A restart exactly at the terminal count suppresses the pulse.
        bus.start = 1'b1; bus.limit = 3'd3; bus.mode = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        chk("term.pre", int'(bus.count), 3);
        bus.start = 1'b1; bus.limit = 3'd7;
        tick();
        bus.start = 1'b0;
        chk_all("term.restart", 0, 1, 0, 0);
        repeat (4) tick();
        chk("clr.pre", int'(bus.count), 4);
        clear = 1'b1;
        bus.pause = 1'b1;
        tick();
        chk_all("clr", 0, 0, 0, 0);
        clear = 1'b0; bus.pause = 1'b0;
        tick();
        chk_all("clr.idle", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
